// File: rtl/proc_status_reg_pkg.sv
// Shared definitions for the 6502 processor status register:
// flag bit positions, explicit flag-op codes and the reset value.
package proc_status_reg_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

  typedef enum logic [2:0] {
    FOP_NOP = 3'd0,
    FOP_CLC = 3'd1,
    FOP_SEC = 3'd2,
    FOP_CLI = 3'd3,
    FOP_SEI = 3'd4,
    FOP_CLV = 3'd5,
    FOP_CLD = 3'd6,
    FOP_SED = 3'd7
  } flag_op_e;

  // Returns {N, Z} for an 8-bit value.
  function automatic logic [1:0] nz_of(input logic [7:0] value);
    return {value[7], (value == 8'h00)};
  endfunction

endpackage

// File: rtl/proc_status_reg.sv
// 6502 status register P (N V - B D I Z C). Six real flag flops; bit5 and
// bit4 are constants, B only exists in the pushed byte.
module proc_status_reg
  import proc_status_reg_pkg::*;
#(
  parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] alu_Y,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  input  logic [7:0] data_in,
  input  logic       nz_src,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_test,
  input  logic [2:0] flag_op,
  input  logic       pull_en,
  input  logic       int_entry,
  input  logic       push_brk,
  output logic [7:0] status,
  output logic [7:0] status_push,
  output logic       flag_c,
  output logic       flag_d
);

  logic n_reg, v_reg, d_reg, i_reg, z_reg, c_reg;
  logic n_next, v_next, d_next, i_next, z_next, c_next;

  flag_op_e   fop;
  logic [1:0] nz_src_val;
  logic       bit_z;
  logic       unused_bits;

  assign fop        = flag_op_e'(flag_op);
  assign nz_src_val = nz_of(nz_src ? data_in : alu_Y);
  assign bit_z      = (alu_Y == 8'h00);
  // Pulled B and bit5 are discarded: those positions are not storage.
  assign unused_bits = &{1'b0, data_in[FLAG_U], data_in[FLAG_B]};

  always_comb begin
    c_next = c_reg;
    if (pull_en)              c_next = data_in[FLAG_C];
    else if (fop == FOP_CLC)  c_next = 1'b0;
    else if (fop == FOP_SEC)  c_next = 1'b1;
    else if (upd_c)           c_next = alu_carry_out;
  end

  always_comb begin
    z_next = z_reg;
    if (pull_en)       z_next = data_in[FLAG_Z];
    else if (bit_test) z_next = bit_z;
    else if (upd_nz)   z_next = nz_src_val[0];
  end

  // Interrupt entry outranks even a pull for I.
  always_comb begin
    i_next = i_reg;
    if (int_entry)            i_next = 1'b1;
    else if (pull_en)         i_next = data_in[FLAG_I];
    else if (fop == FOP_CLI)  i_next = 1'b0;
    else if (fop == FOP_SEI)  i_next = 1'b1;
  end

  always_comb begin
    d_next = d_reg;
    if (pull_en)              d_next = data_in[FLAG_D];
    else if (fop == FOP_CLD)  d_next = 1'b0;
    else if (fop == FOP_SED)  d_next = 1'b1;
  end

  always_comb begin
    v_next = v_reg;
    if (pull_en)              v_next = data_in[FLAG_V];
    else if (fop == FOP_CLV)  v_next = 1'b0;
    else if (bit_test)        v_next = data_in[FLAG_V];
    else if (upd_v)           v_next = alu_overflow;
  end

  always_comb begin
    n_next = n_reg;
    if (pull_en)       n_next = data_in[FLAG_N];
    else if (bit_test) n_next = data_in[FLAG_N];
    else if (upd_nz)   n_next = nz_src_val[1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      n_reg <= RESET_P[FLAG_N];
      v_reg <= RESET_P[FLAG_V];
      d_reg <= RESET_P[FLAG_D];
      i_reg <= RESET_P[FLAG_I];
      z_reg <= RESET_P[FLAG_Z];
      c_reg <= RESET_P[FLAG_C];
    end else begin
      n_reg <= n_next;
      v_reg <= v_next;
      d_reg <= d_next;
      i_reg <= i_next;
      z_reg <= z_next;
      c_reg <= c_next;
    end
  end

  assign status      = {n_reg, v_reg, 1'b1, 1'b0, d_reg, i_reg, z_reg, c_reg};
  assign status_push = {n_reg, v_reg, 1'b1, push_brk, d_reg, i_reg, z_reg, c_reg};
  assign flag_c      = c_reg;
  assign flag_d      = d_reg;

endmodule

// File: tb/tb_proc_status_reg.sv
// Directed, table-driven bench for proc_status_reg with hand-written
// sequences for asynchronous reset behaviour.
module tb_proc_status_reg;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] alu_Y;
  logic       alu_carry_out;
  logic       alu_overflow;
  logic [7:0] data_in;
  logic       nz_src;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic       bit_test;
  logic [2:0] flag_op;
  logic       pull_en;
  logic       int_entry;
  logic       push_brk;
  logic [7:0] status;
  logic [7:0] status_push;
  logic       flag_c;
  logic       flag_d;

  int checks   = 0;
  int failures = 0;

  proc_status_reg dut (
    .clk          (clk),
    .resetn       (resetn),
    .alu_Y        (alu_Y),
    .alu_carry_out(alu_carry_out),
    .alu_overflow (alu_overflow),
    .data_in      (data_in),
    .nz_src       (nz_src),
    .upd_nz       (upd_nz),
    .upd_c        (upd_c),
    .upd_v        (upd_v),
    .bit_test     (bit_test),
    .flag_op      (flag_op),
    .pull_en      (pull_en),
    .int_entry    (int_entry),
    .push_brk     (push_brk),
    .status       (status),
    .status_push  (status_push),
    .flag_c       (flag_c),
    .flag_d       (flag_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] alu_y;
    logic       co;
    logic       ov;
    logic [7:0] data;
    logic       nz_src;
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic       bit_test;
    logic [2:0] fop;
    logic       pull;
    logic       intr;
    logic       brk;
    logic [7:0] exp;
  } vec_t;

  localparam logic [2:0] NOP = 3'd0, CLC = 3'd1, SEC = 3'd2, CLI = 3'd3,
                         SEI = 3'd4, CLV = 3'd5, CLD = 3'd6, SED = 3'd7;

  function automatic vec_t mk(string name, logic [7:0] alu_y, logic co, logic ov,
                              logic [7:0] data, logic nzs, logic unz, logic uc,
                              logic uv, logic bt, logic [2:0] fop, logic pull,
                              logic intr, logic brk, logic [7:0] exp);
    vec_t v;
    v.name = name; v.alu_y = alu_y; v.co = co; v.ov = ov; v.data = data;
    v.nz_src = nzs; v.upd_nz = unz; v.upd_c = uc; v.upd_v = uv; v.bit_test = bt;
    v.fop = fop; v.pull = pull; v.intr = intr; v.brk = brk; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_Y = 8'h00; alu_carry_out = 1'b0; alu_overflow = 1'b0; data_in = 8'h00;
    nz_src = 1'b0; upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0; bit_test = 1'b0;
    flag_op = NOP; pull_en = 1'b0; int_entry = 1'b0; push_brk = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    alu_Y = v.alu_y; alu_carry_out = v.co; alu_overflow = v.ov; data_in = v.data;
    nz_src = v.nz_src; upd_nz = v.upd_nz; upd_c = v.upd_c; upd_v = v.upd_v;
    bit_test = v.bit_test; flag_op = v.fop; pull_en = v.pull; int_entry = v.intr;
    push_brk = v.brk;
  endtask

  vec_t vecs[$];
  logic [7:0] prev_exp;

  initial begin
    //            name           aluY  co  ov  data  nzs unz uc  uv  bt  fop  pull int brk exp
    vecs.push_back(mk("alu_neg_v",  8'h80, 0, 1, 8'h00, 0, 1, 1, 1, 0, NOP, 0, 0, 0, 8'hE4));
    vecs.push_back(mk("alu_zero_c", 8'h00, 1, 0, 8'h00, 0, 1, 1, 1, 0, NOP, 0, 0, 1, 8'h27));
    vecs.push_back(mk("pull_ff",    8'h00, 0, 0, 8'hFF, 0, 0, 1, 0, 0, NOP, 1, 0, 0, 8'hEF));
    vecs.push_back(mk("pull_00",    8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, NOP, 1, 0, 1, 8'h20));
    vecs.push_back(mk("sec_vs_c",   8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, SEC, 0, 0, 0, 8'h21));
    vecs.push_back(mk("pull_int",   8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, NOP, 1, 1, 0, 8'h24));
    vecs.push_back(mk("bit_c0",     8'h00, 0, 0, 8'hC0, 0, 1, 0, 0, 1, NOP, 0, 0, 0, 8'hE6));
    vecs.push_back(mk("nz_data_0",  8'hFF, 0, 0, 8'h00, 1, 1, 0, 0, 0, NOP, 0, 0, 0, 8'h66));
    vecs.push_back(mk("nz_data_85", 8'h00, 0, 0, 8'h85, 1, 1, 0, 0, 0, NOP, 0, 0, 0, 8'hE4));
    vecs.push_back(mk("clv",        8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, CLV, 0, 0, 0, 8'hA4));
    vecs.push_back(mk("sed",        8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, SED, 0, 0, 1, 8'hAC));
    vecs.push_back(mk("cli",        8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, CLI, 0, 0, 0, 8'hA8));
    vecs.push_back(mk("sei",        8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, SEI, 0, 0, 0, 8'hAC));
    vecs.push_back(mk("cld",        8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, CLD, 0, 0, 0, 8'hA4));
    vecs.push_back(mk("sec",        8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, SEC, 0, 0, 0, 8'hA5));
    vecs.push_back(mk("clc_vs_c",   8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 0, CLC, 0, 0, 0, 8'hA4));
    vecs.push_back(mk("upd_c",      8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 0, NOP, 0, 0, 0, 8'hA5));
    vecs.push_back(mk("upd_v",      8'h00, 0, 1, 8'h00, 0, 0, 0, 1, 0, NOP, 0, 0, 0, 8'hE5));
    vecs.push_back(mk("clv_vs_v",   8'h00, 0, 1, 8'h00, 0, 0, 0, 1, 0, CLV, 0, 0, 0, 8'hA5));
    vecs.push_back(mk("bit_vs_nz",  8'h05, 0, 0, 8'h00, 1, 1, 0, 0, 1, NOP, 0, 0, 0, 8'h25));
    vecs.push_back(mk("idle_junk",  8'hAA, 1, 1, 8'h5A, 1, 0, 0, 0, 0, NOP, 0, 0, 1, 8'h25));
    vecs.push_back(mk("cli2",       8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, CLI, 0, 0, 0, 8'h21));
    vecs.push_back(mk("int_vs_cli", 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, CLI, 0, 1, 0, 8'h25));
    vecs.push_back(mk("pull_30",    8'h00, 0, 0, 8'h30, 0, 0, 0, 0, 0, NOP, 1, 0, 0, 8'h20));

    idle_inputs();
    resetn = 1'b1;
    #3 resetn = 1'b0;
    #1;
    chk("reset_status", status, 8'h24);
    chk("reset_flag_c", {7'd0, flag_c}, 8'h00);
    chk("reset_flag_d", {7'd0, flag_d}, 8'h00);
    $display("reset asserted: status=%h", status);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_hold", status, 8'h24);
    end
    chk("push_b0", status_push, 8'h24);
    push_brk = 1'b1;
    #1 chk("push_b1", status_push, 8'h34);
    $display("idle x5: status=%h", status);

    prev_exp = 8'h24;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      // Pushed byte reflects the pre-edge status only.
      chk({vecs[i].name, "_push_pre"}, status_push,
          (prev_exp & 8'hEF) | (vecs[i].brk ? 8'h10 : 8'h00));
      @(negedge clk);
      chk({vecs[i].name, "_status"}, status, vecs[i].exp);
      chk({vecs[i].name, "_flag_c"}, {7'd0, flag_c}, {7'd0, vecs[i].exp[0]});
      chk({vecs[i].name, "_flag_d"}, {7'd0, flag_d}, {7'd0, vecs[i].exp[3]});
      chk({vecs[i].name, "_push_post"}, status_push,
          (vecs[i].exp & 8'hEF) | (vecs[i].brk ? 8'h10 : 8'h00));
      $display("vec %0d %s: status=%h expected=%h", i, vecs[i].name, status, vecs[i].exp);
      prev_exp = vecs[i].exp;
    end

    // Build nonreset state, then assert reset mid-cycle while an update is pending.
    idle_inputs();
    data_in = 8'hCB; pull_en = 1'b1;
    @(negedge clk);
    chk("pre_reset_pull", status, 8'hEB);
    pull_en = 1'b0; flag_op = SED; upd_c = 1'b0; upd_nz = 1'b1; alu_Y = 8'h80;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_status", status, 8'h24);
    chk("async_reset_flag_c", {7'd0, flag_c}, 8'h00);
    @(negedge clk);
    chk("reset_held_edge", status, 8'h24);
    idle_inputs();
    flag_op = SEC;
    resetn  = 1'b1;
    @(negedge clk);
    chk("first_edge_after_reset", status, 8'h25);
    chk("first_edge_flag_d", {7'd0, flag_d}, 8'h00);
    $display("reset mid-update: status=%h", status);
    idle_inputs();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
